// File: rtl/mem_port_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_master_if
// Description : Bundles the command/response handshake of a memory requester
//               together with its memory-controller port.
//               master : the requester (mem_port_master) view
//               slave  : the core + memory-controller environment view
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata : core command channel
//   rsp_valid/rsp_rdata/rsp_err                   : core response strobe
//   rden/wren/Address/Din                         : requests to controller
//   acq/Dq                                        : grant and RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rden;
  logic       wren;
  logic [7:0] Address;
  logic [7:0] Din;
  logic       acq;
  logic [7:0] Dq;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, acq, Dq,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rden, wren, Address, Din
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, acq, Dq,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rden, wren, Address, Din
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_master
// Description : Requester end of one memory-controller port. Accepts core
//               commands (one active + one pending), holds rden/wren until the
//               controller grants with acq, honours the one-cycle read latency
//               of the synchronous RAM and returns a one-cycle response.
//               Requests not granted within TIMEOUT cycles end with rsp_err.
// Ports       : clk   - single clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - mem_port_master_if.master (command, response and
//                       controller-port signals)
// Parameters  : TIMEOUT - REQ cycles without acq before abandoning a request
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_master #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  wire                  clk,
  input  wire                  rst_n,
  mem_port_master_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t     state_q, state_d;

  // Active command
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  // One-deep pending buffer
  logic       pending_full_q, pending_full_d;
  logic       pend_we_q, pend_we_d;
  logic [7:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_wdata_q, pend_wdata_d;

  // Grant wait counter and response payload
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  logic       xfer;
  logic [7:0] wait_inc;
  logic       rden_o, wren_o;
  logic [7:0] address_o, din_o;

  assign xfer     = bus.cmd_valid & ~pending_full_q;
  assign wait_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    pending_full_d = pending_full_q;
    pend_we_d      = pend_we_q;
    pend_addr_d    = pend_addr_q;
    pend_wdata_d   = pend_wdata_q;
    wait_cnt_d     = wait_cnt_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    rden_o         = 1'b0;
    wren_o         = 1'b0;
    address_o      = 8'd0;
    din_o          = 8'd0;

    // Any command accepted while busy (REQ, RDWAIT or RESP) is parked in the
    // pending slot; it can only be accepted when that slot is empty.
    if (xfer && (state_q != S_IDLE)) begin
      pending_full_d = 1'b1;
      pend_we_d      = bus.cmd_we;
      pend_addr_d    = bus.cmd_addr;
      pend_wdata_d   = bus.cmd_wdata;
    end

    case (state_q)
      S_IDLE: begin
        // A command parked during the previous RESP is served before any new
        // one; cmd_ready is low meanwhile, so no transfer can collide.
        if (pending_full_q) begin
          we_d           = pend_we_q;
          addr_d         = pend_addr_q;
          wdata_d        = pend_wdata_q;
          pending_full_d = 1'b0;
          wait_cnt_d     = 8'd0;
          state_d        = S_REQ;
        end else if (xfer) begin
          we_d       = bus.cmd_we;
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          wait_cnt_d = 8'd0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        rden_o    = ~we_q;
        wren_o    = we_q;
        address_o = addr_q;
        din_o     = wdata_q;
        if (bus.acq) begin
          // A grant always wins, even in the cycle the counter would expire.
          if (we_q) begin
            rdata_d = 8'd0;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_RDWAIT;
          end
        end else begin
          // The counter holds the number of ungranted REQ cycles so far,
          // including this one once incremented.
          wait_cnt_d = wait_inc;
          if (wait_inc == TIMEOUT) begin
            rdata_d = 8'd0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_RDWAIT: begin
        // RAM q becomes valid one cycle after the granted read edge.
        rden_o    = 1'b1;
        address_o = addr_q;
        din_o     = wdata_q;
        rdata_d   = bus.Dq;
        err_d     = 1'b0;
        state_d   = S_RESP;
      end

      S_RESP: begin
        if (pending_full_q) begin
          we_d           = pend_we_q;
          addr_d         = pend_addr_q;
          wdata_d        = pend_wdata_q;
          pending_full_d = 1'b0;
          wait_cnt_d     = 8'd0;
          state_d        = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      we_q           <= 1'b0;
      addr_q         <= 8'd0;
      wdata_q        <= 8'd0;
      pending_full_q <= 1'b0;
      pend_we_q      <= 1'b0;
      pend_addr_q    <= 8'd0;
      pend_wdata_q   <= 8'd0;
      wait_cnt_q     <= 8'd0;
      rdata_q        <= 8'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      pending_full_q <= pending_full_d;
      pend_we_q      <= pend_we_d;
      pend_addr_q    <= pend_addr_d;
      pend_wdata_q   <= pend_wdata_d;
      wait_cnt_q     <= wait_cnt_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
    end
  end

  // All outputs decode from reset flops so they drop as soon as rst_n falls.
  assign bus.cmd_ready = ~pending_full_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : 8'd0;
  assign bus.rsp_err   = (state_q == S_RESP) & err_q;
  assign bus.rden      = rden_o;
  assign bus.wren      = wren_o;
  assign bus.Address   = address_o;
  assign bus.Din       = din_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_master
// Description : Three requesters on a modelled 3-port controller with a shared
//               synchronous RAM. Port 1 uses TIMEOUT=4, ports 0 and 2 the
//               default. Expected responses are queued per port when a command
//               is accepted; a monitor pops and compares on every rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_master;

  logic       clk;
  logic       rst_n;

  logic [2:0] cmd_valid, cmd_we, cmd_ready;
  logic [2:0] rsp_valid, rsp_err, rden, wren;
  logic [7:0] cmd_addr  [3];
  logic [7:0] cmd_wdata [3];
  logic [7:0] rsp_rdata [3];
  logic [7:0] address   [3];
  logic [7:0] din       [3];
  logic [7:0] ram_q;

  // Controller / RAM model
  logic [2:0] req, acq;
  bit   [2:0] rd_excl_q;
  logic       found;
  int         rc    [3];
  int         delay [3];
  logic [7:0] mem   [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  // Scoreboard
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];
  logic [8:0] exp_q2 [$];
  int         n_checks;
  int         n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_port
    mem_port_master_if bus ();
    assign bus.cmd_valid = cmd_valid[g];
    assign bus.cmd_we    = cmd_we[g];
    assign bus.cmd_addr  = cmd_addr[g];
    assign bus.cmd_wdata = cmd_wdata[g];
    assign bus.acq       = acq[g];
    assign bus.Dq        = ram_q;
    assign cmd_ready[g]  = bus.cmd_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;
    assign rden[g]       = bus.rden;
    assign wren[g]       = bus.wren;
    assign address[g]    = bus.Address;
    assign din[g]        = bus.Din;

    mem_port_master #(
      .TIMEOUT((g == 1) ? 8'd4 : 8'd255)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );
  end

  // Fixed-priority arbiter: one grant per cycle, a port is skipped in the
  // cycle after its read grant, and delay[i] holds acq off for that many
  // requesting cycles.
  assign req = rden | wren;

  always_comb begin
    acq   = 3'b000;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[i] && !rd_excl_q[i] && (rc[i] >= delay[i])) begin
        acq[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    rd_excl_q <= acq & rden;
    for (int i = 0; i < 3; i++) begin
      rc[i] <= req[i] ? rc[i] + 1 : 0;
    end
    if (pl_en) mem[pl_addr] <= pl_data;
    for (int i = 0; i < 3; i++) begin
      if (acq[i] && wren[i]) mem[address[i]] <= din[i];
      if (acq[i] && rden[i]) ram_q <= mem[address[i]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic int q_size(input int p);
    case (p)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic void q_push(input int p, input logic [8:0] v);
    case (p)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic logic [8:0] q_pop(input int p);
    case (p)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (rsp_valid[p]) begin
          if (q_size(p) == 0) begin
            n_checks++;
            $display("FAIL rsp_p%0d_unexpected: got response 0x%0h, required none",
                     p, {rsp_err[p], rsp_rdata[p]});
          end else begin
            check($sformatf("rsp_p%0d", p), {23'd0, rsp_err[p], rsp_rdata[p]},
                  {23'd0, q_pop(p)});
          end
        end
      end
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called and returns at posedge+1; returns just after the accept edge.
  task automatic issue(input int p, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [8:0] exp, input bit push);
    logic hs;
    int   n;
    hs = 1'b0;
    n  = 0;
    cmd_valid[p] = 1'b1; cmd_we[p] = we; cmd_addr[p] = addr; cmd_wdata[p] = wdata;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = cmd_ready[p];
      @(posedge clk); #1;
      n++;
    end
    cmd_valid[p] = 1'b0;
    if (!hs) check($sformatf("accept_p%0d", p), 32'd0, 32'd1);
    else if (push) q_push(p, exp);
  endtask

  // Latency counts the accept cycle as cycle 1; active counts rden|wren cycles.
  task automatic run_one(input string name, input int p, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [8:0] exp, input int exp_lat, input int exp_act);
    int  n;
    int  act;
    bit  done;
    issue(p, we, addr, wdata, exp, 1'b1);
    n = 1; act = 0; done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (rden[p] || wren[p]) act++;
      if (rsp_valid[p]) done = 1'b1;
    end
    @(posedge clk); #1;
    check({name, "_latency"}, n, exp_lat);
    check({name, "_active"}, act, exp_act);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_size(0) + q_size(1) + q_size(2)) != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_drain"}, q_size(0) + q_size(1) + q_size(2), 0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    cmd_valid = '0;
    cmd_we    = '0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    for (int i = 0; i < 3; i++) begin
      cmd_addr[i] = '0; cmd_wdata[i] = '0; delay[i] = 0;
    end
    fork
      monitor();
    join_none

    poke(8'h10, 8'hA5);
    poke(8'h01, 8'h5A);
    poke(8'h40, 8'h77);
    poke(8'h41, 8'h11);
    poke(8'h30, 8'hB0);
    poke(8'h31, 8'hB1);
    poke(8'h32, 8'hB2);

    // Reset state
    check("reset_ready", {29'd0, cmd_ready}, 32'd7);
    check("reset_rden_wren", {26'd0, rden, wren}, 32'd0);
    check("reset_rsp", {23'd0, rsp_valid, rsp_err, 3'd0}, 32'd0);
    check("reset_bus0", {8'd0, address[0], din[0], rsp_rdata[0]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read with immediate grant
    run_one("rd_fast", 0, 1'b0, 8'h10, 8'h00, {1'b0, 8'hA5}, 4, 2);

    // Write with grant delayed 5 cycles
    delay[0] = 5;
    run_one("wr_slow", 0, 1'b1, 8'h20, 8'h3C, {1'b0, 8'h00}, 8, 6);
    check("wr_slow_ram", {24'd0, mem[8'h20]}, 32'h3C);
    delay[0] = 0;

    // Timeouts on port 1 (TIMEOUT=4)
    delay[1] = 1000;
    run_one("to_rd", 1, 1'b0, 8'h40, 8'h00, {1'b1, 8'h00}, 6, 4);
    run_one("to_wr", 1, 1'b1, 8'h41, 8'hEE, {1'b1, 8'h00}, 6, 4);
    check("to_wr_ram", {24'd0, mem[8'h41]}, 32'h11);

    // Grant in the cycle the counter would expire wins
    delay[1] = 3;
    run_one("to_edge", 1, 1'b0, 8'h40, 8'h00, {1'b0, 8'h77}, 7, 5);
    delay[1] = 0;

    // Back-to-back: second command parks in the pending slot
    issue(0, 1'b0, 8'h01, 8'h00, {1'b0, 8'h5A}, 1'b1);
    issue(0, 1'b1, 8'h02, 8'hC3, {1'b0, 8'h00}, 1'b1);
    @(negedge clk);
    check("b2b_ready_low", {31'd0, cmd_ready[0]}, 32'd0);
    @(posedge clk); #1;
    drain("b2b");
    check("b2b_ram", {24'd0, mem[8'h02]}, 32'hC3);

    // Command accepted in the RESP cycle is served next, in order
    issue(0, 1'b1, 8'h03, 8'h99, {1'b0, 8'h00}, 1'b1);
    @(posedge clk); #1;
    issue(0, 1'b0, 8'h03, 8'h00, {1'b0, 8'h99}, 1'b1);
    @(negedge clk);
    check("resp_xfer_ready_low", {31'd0, cmd_ready[0]}, 32'd0);
    @(posedge clk); #1;
    drain("resp_xfer");

    // Three ports requesting at once
    cmd_valid = 3'b111;
    cmd_we    = 3'b000;
    cmd_addr[0] = 8'h30; cmd_addr[1] = 8'h31; cmd_addr[2] = 8'h32;
    @(negedge clk);
    check("multi_ready", {29'd0, cmd_ready}, 32'd7);
    @(posedge clk); #1;
    cmd_valid = 3'b000;
    q_push(0, {1'b0, 8'hB0});
    q_push(1, {1'b0, 8'hB1});
    q_push(2, {1'b0, 8'hB2});
    drain("multi");

    // Reset during RDWAIT abandons the read without a response
    issue(0, 1'b0, 8'h10, 8'h00, 9'd0, 1'b0);
    @(posedge clk); #1;
    check("rst_mid_rdwait_rden", {31'd0, rden[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {24'd0, rden[0], wren[0], rsp_valid[0], rsp_err[0], cmd_ready[0], 3'd0},
          32'h08 << 0);
    check("rst_mid_bus", {16'd0, address[0], rsp_rdata[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one("rd_after_rst", 0, 1'b0, 8'h10, 8'h00, {1'b0, 8'hA5}, 4, 2);
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
